brq_resolve: RTL and testbench

BRQ_RESOLVE -- requirements
Module: brq_resolve

---
 rtl/brq_if.sv | 35 +++
 rtl/brq_resolve.sv | 108 ++++++++++
 tb/tb_brq_resolve.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/brq_if.sv
// Handshake bundle for the branch resolve queue: dispatch allocations and
// execute results in, in-order resolution pulses and flush information out.
interface brq_if #(
  parameter int SPTAG_WIDTH = 5,
  parameter int PC_WIDTH    = 32
);
  localparam int CW = $clog2(SPTAG_WIDTH);

  logic                   i_alloc_1;
  logic                   i_alloc_2;
  logic [SPTAG_WIDTH-1:0] i_alloc_tag_1;
  logic [SPTAG_WIDTH-1:0] i_alloc_tag_2;
  logic                   i_ex_valid;
  logic [SPTAG_WIDTH-1:0] i_ex_tag;
  logic                   i_ex_miss;
  logic [PC_WIDTH-1:0]    i_ex_target;
  logic                   o_prsuc;
  logic                   o_prmiss;
  logic [PC_WIDTH-1:0]    o_prmiss_pc;
  logic [SPTAG_WIDTH-1:0] o_sptag_fix;
  logic [CW-1:0]          o_count;
  logic                   o_ovf;

  modport master (
    output i_alloc_1, i_alloc_2, i_alloc_tag_1, i_alloc_tag_2,
           i_ex_valid, i_ex_tag, i_ex_miss, i_ex_target,
    input  o_prsuc, o_prmiss, o_prmiss_pc, o_sptag_fix, o_count, o_ovf
  );

  modport slave (
    input  i_alloc_1, i_alloc_2, i_alloc_tag_1, i_alloc_tag_2,
           i_ex_valid, i_ex_tag, i_ex_miss, i_ex_target,
    output o_prsuc, o_prmiss, o_prmiss_pc, o_sptag_fix, o_count, o_ovf
  );
endinterface

// File: rtl/brq_resolve.sv
// Branch resolve queue: tracks in-flight branches in program order and
// retires them from the head, either as a success pop or a full flush.
module brq_resolve #(
  parameter int SPTAG_WIDTH = 5,
  parameter int PC_WIDTH    = 32
) (
  input  logic  clk,
  input  logic  rst,
  brq_if.slave  bus
);
  localparam int D  = SPTAG_WIDTH - 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  typedef struct packed {
    logic                   valid;
    logic [SPTAG_WIDTH-1:0] tag;
    logic                   done;
    logic                   miss;
    logic [PC_WIDTH-1:0]    target;
  } entry_t;

  entry_t          q [D];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   cnt;

  entry_t          hd;
  logic            pop, flush, blk_alloc, take1, take2, drop;
  logic [PW-1:0]   slot1, slot2, tail_nxt;
  logic [D-1:0]    ex_hit;
  int              free_slots;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == D - 1) ? '0 : p + PW'(1);
  endfunction

  function automatic entry_t mk(input logic [SPTAG_WIDTH-1:0] t);
    entry_t e;
    e       = '0;
    e.valid = 1'b1;
    e.tag   = t;
    return e;
  endfunction

  always_comb begin
    hd        = q[head];
    pop       = hd.valid & hd.done & ~hd.miss;
    flush     = hd.valid & hd.done & hd.miss;
    // a flush in flight, or its visible pulse, kills new dispatch
    blk_alloc = flush | bus.o_prmiss;
    // capacity is judged after this cycle's pop so a full queue can still refill
    free_slots = D - int'(cnt) + int'(pop);
    take1     = bus.i_alloc_1 & ~blk_alloc & (free_slots >= 1);
    take2     = bus.i_alloc_2 & ~blk_alloc & (free_slots >= 1 + int'(take1));
    drop      = ~blk_alloc & ((bus.i_alloc_1 & ~take1) | (bus.i_alloc_2 & ~take2));
    slot1     = tail;
    slot2     = take1 ? inc(tail) : tail;
    tail_nxt  = take2 ? inc(slot2) : slot2;
    for (int i = 0; i < D; i++)
      ex_hit[i] = bus.i_ex_valid & ~flush & q[i].valid & ~q[i].done &
                  (q[i].tag == bus.i_ex_tag);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) q[i] <= '0;
      head            <= '0;
      tail            <= '0;
      cnt             <= '0;
      bus.o_prsuc     <= 1'b0;
      bus.o_prmiss    <= 1'b0;
      bus.o_ovf       <= 1'b0;
      bus.o_prmiss_pc <= '0;
      bus.o_sptag_fix <= '0;
    end else begin
      bus.o_prsuc  <= pop;
      bus.o_prmiss <= flush;
      bus.o_ovf    <= drop;
      if (flush) begin
        bus.o_prmiss_pc <= hd.target;
        bus.o_sptag_fix <= hd.tag;
        for (int i = 0; i < D; i++) q[i] <= '0;
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        for (int i = 0; i < D; i++) begin
          if (ex_hit[i]) begin
            q[i].done   <= 1'b1;
            q[i].miss   <= bus.i_ex_miss;
            q[i].target <= bus.i_ex_target;
          end
        end
        if (pop) begin
          q[head].valid <= 1'b0;
          head          <= inc(head);
        end
        // allocation last: on a full queue it may reuse the slot just popped
        if (take1) q[slot1] <= mk(bus.i_alloc_tag_1);
        if (take2) q[slot2] <= mk(bus.i_alloc_tag_2);
        tail <= tail_nxt;
        cnt  <= cnt - CW'(pop) + CW'(take1) + CW'(take2);
      end
    end
  end

  assign bus.o_count = cnt;
endmodule

// File: tb/tb_brq_resolve.sv
// Directed bench for brq_resolve: a queue-level model predicts every output
// each cycle, and literal expectations pin the key scenarios.
module tb_brq_resolve;
  localparam int SW = 5;
  localparam int PCW = 32;
  localparam int D = SW - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  brq_if #(.SPTAG_WIDTH(SW), .PC_WIDTH(PCW)) bus ();
  brq_resolve #(.SPTAG_WIDTH(SW), .PC_WIDTH(PCW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tot = 0;
  int n_pass = 0;

  typedef struct {
    logic [SW-1:0]  tag;
    bit             done;
    bit             miss;
    logic [PCW-1:0] tgt;
  } ment_t;

  ment_t          mq[$];
  bit             e_prsuc, e_prmiss, e_ovf;
  logic [PCW-1:0] e_pc;
  logic [SW-1:0]  e_fix;
  bit             chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    mq.delete();
    e_prsuc = 0; e_prmiss = 0; e_ovf = 0; e_pc = '0; e_fix = '0;
  endtask

  // One clock of queue semantics: resolve head, then results, then dispatch.
  task automatic model_step();
    bit fl, pp, ov, prev_pm;
    fl = 0; pp = 0; ov = 0;
    prev_pm = e_prmiss;
    if (mq.size() > 0 && mq[0].done) begin
      if (mq[0].miss) begin
        fl = 1; e_pc = mq[0].tgt; e_fix = mq[0].tag; mq.delete();
      end else begin
        pp = 1; void'(mq.pop_front());
      end
    end
    if (!fl) begin
      if (bus.i_ex_valid)
        foreach (mq[i])
          if (!mq[i].done && mq[i].tag == bus.i_ex_tag) begin
            mq[i].done = 1; mq[i].miss = bus.i_ex_miss; mq[i].tgt = bus.i_ex_target;
          end
      if (!prev_pm) begin
        if (bus.i_alloc_1) begin
          if (mq.size() < D) mq.push_back('{bus.i_alloc_tag_1, 0, 0, '0}); else ov = 1;
        end
        if (bus.i_alloc_2) begin
          if (mq.size() < D) mq.push_back('{bus.i_alloc_tag_2, 0, 0, '0}); else ov = 1;
        end
      end
    end
    e_prsuc = pp; e_prmiss = fl; e_ovf = ov;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_prsuc", 64'(bus.o_prsuc), 64'(e_prsuc));
      chk("m_prmiss", 64'(bus.o_prmiss), 64'(e_prmiss));
      chk("m_ovf", 64'(bus.o_ovf), 64'(e_ovf));
      chk("m_count", 64'(bus.o_count), 64'(mq.size()));
      chk("m_pc", 64'(bus.o_prmiss_pc), 64'(e_pc));
      chk("m_fix", 64'(bus.o_sptag_fix), 64'(e_fix));
    end
  end

  task automatic clr();
    bus.i_alloc_1 = 0; bus.i_alloc_2 = 0; bus.i_alloc_tag_1 = '0; bus.i_alloc_tag_2 = '0;
    bus.i_ex_valid = 0; bus.i_ex_tag = '0; bus.i_ex_miss = 0; bus.i_ex_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    clr();
  endtask

  task automatic alloc(input bit a1, input logic [SW-1:0] t1, input bit a2, input logic [SW-1:0] t2);
    bus.i_alloc_1 = a1; bus.i_alloc_tag_1 = t1; bus.i_alloc_2 = a2; bus.i_alloc_tag_2 = t2;
    tick();
  endtask

  task automatic ex(input logic [SW-1:0] t, input bit miss, input logic [PCW-1:0] tgt);
    bus.i_ex_valid = 1; bus.i_ex_tag = t; bus.i_ex_miss = miss; bus.i_ex_target = tgt;
    tick();
  endtask

  initial begin
    clr();
    model_reset();
    #1;
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_prsuc", 64'(bus.o_prsuc), 64'd0);
    chk("rst_pc", 64'(bus.o_prmiss_pc), 64'd0);
    tick(); tick();
    rst = 0;
    chk_en = 1;
    tick();

    // single hit at head
    alloc(1, 5'b00010, 1, 5'b00100);
    chk("t1_count2", 64'(bus.o_count), 64'd2);
    ex(5'b00010, 0, 32'h0);
    chk("t1_noearly", 64'(bus.o_prsuc), 64'd0);
    tick();
    chk("t1_prsuc", 64'(bus.o_prsuc), 64'd1);
    chk("t1_count1", 64'(bus.o_count), 64'd1);
    ex(5'b00100, 0, 32'h0);
    tick(); tick();
    chk("t1_empty", 64'(bus.o_count), 64'd0);

    // younger resolves first, older releases both in order
    alloc(1, 5'b00010, 1, 5'b00100);
    ex(5'b00100, 0, 32'h0);
    ex(5'b00010, 0, 32'h0);
    chk("t2_wait", 64'(bus.o_prsuc), 64'd0);
    tick();
    chk("t2_p1", 64'(bus.o_prsuc), 64'd1);
    chk("t2_c1", 64'(bus.o_count), 64'd1);
    tick();
    chk("t2_p2", 64'(bus.o_prsuc), 64'd1);
    chk("t2_c0", 64'(bus.o_count), 64'd0);
    tick();

    // head mispredict flushes younger done entry
    alloc(1, 5'b00010, 1, 5'b00100);
    alloc(0, 5'b00000, 1, 5'b01000);
    chk("t3_count3", 64'(bus.o_count), 64'd3);
    ex(5'b00100, 0, 32'h0);
    ex(5'b00010, 1, 32'h0000_1000);
    tick();
    chk("t3_prmiss", 64'(bus.o_prmiss), 64'd1);
    chk("t3_pc", 64'(bus.o_prmiss_pc), 64'h1000);
    chk("t3_fix", 64'(bus.o_sptag_fix), 64'b00010);
    chk("t3_count0", 64'(bus.o_count), 64'd0);
    chk("t3_noprsuc", 64'(bus.o_prsuc), 64'd0);
    alloc(1, 5'b00010, 0, 5'b00000);
    chk("t3_alloc_discard", 64'(bus.o_count), 64'd0);
    chk("t3_hold_pc", 64'(bus.o_prmiss_pc), 64'h1000);
    tick();

    // overflow: full queue, then full queue with a pop
    alloc(1, 5'b00010, 1, 5'b00100);
    alloc(1, 5'b01000, 1, 5'b10000);
    chk("t4_full", 64'(bus.o_count), 64'd4);
    alloc(1, 5'b00001, 1, 5'b00010);
    chk("t4_ovf", 64'(bus.o_ovf), 64'd1);
    chk("t4_count4", 64'(bus.o_count), 64'd4);
    tick();
    chk("t4_ovf_pulse", 64'(bus.o_ovf), 64'd0);
    ex(5'b00010, 0, 32'h0);
    alloc(1, 5'b00001, 1, 5'b00010);
    chk("t4_pop_prsuc", 64'(bus.o_prsuc), 64'd1);
    chk("t4_pop_count", 64'(bus.o_count), 64'd4);
    chk("t4_pop_ovf", 64'(bus.o_ovf), 64'd1);

    // drain, then a second group across the pointer wrap
    ex(5'b00100, 0, 32'h0);
    ex(5'b01000, 0, 32'h0);
    ex(5'b10000, 0, 32'h0);
    ex(5'b00001, 0, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("t5_drained", 64'(bus.o_count), 64'd0);
    alloc(1, 5'b00010, 1, 5'b00100);
    alloc(1, 5'b01000, 1, 5'b10000);
    chk("t5_refill", 64'(bus.o_count), 64'd4);
    ex(5'b10000, 0, 32'h0);
    ex(5'b10000, 1, 32'hdead_beef);
    ex(5'b00001, 1, 32'hdead_beef);
    ex(5'b01000, 0, 32'h0);
    ex(5'b00100, 0, 32'h0);
    ex(5'b00010, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_prsuc", 64'(bus.o_prsuc), 64'd1);
      chk("t5_count", 64'(bus.o_count), 64'(3 - k));
    end
    tick();
    chk("t5_noflush", 64'(bus.o_prmiss), 64'd0);

    // reset right after a head miss result lands
    alloc(1, 5'b00010, 0, 5'b00000);
    ex(5'b00010, 1, 32'h0000_2000);
    rst = 1;
    model_reset();
    #1;
    chk("t6_pc0", 64'(bus.o_prmiss_pc), 64'd0);
    chk("t6_count0", 64'(bus.o_count), 64'd0);
    tick();
    chk("t6_noprmiss", 64'(bus.o_prmiss), 64'd0);
    chk("t6_fix0", 64'(bus.o_sptag_fix), 64'd0);
    rst = 0;
    tick();
    chk("t6_after_prmiss", 64'(bus.o_prmiss), 64'd0);
    chk("t6_after_prsuc", 64'(bus.o_prsuc), 64'd0);
    tick();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
